// File: rtl/axis_uart_pkg.sv
// Shared UART definitions: frame constants, receiver/transmitter state encoding,
// the parity helper and the receiver status word.
package axis_uart_pkg;

   localparam int DATA_WIDTH    = 8;
   localparam int DIVIDER_WIDTH = 32;

   typedef enum logic [2:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_PARITY,
      UART_STOP,
      UART_WAIT
   } uart_state_e;

   typedef struct packed {
      logic overrun;
      logic frame_err;
      logic parity_err;
   } uart_rx_status_t;

   // Value the parity bit must carry for the given payload.
   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
      return odd ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/axis_uart_rx_sync.sv
// Metastability synchroniser for the serial line; every stage resets to the
// idle-high level so a reset never looks like a start bit.
module axis_uart_rx_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else if (clr_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver with an AXI-Stream master output. Define AXIS_UART_RX_MAJORITY_EN
// to take each bit as a 3-sample majority vote around the sample point.
module axis_uart_rx
   import axis_uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
   input  logic                     parity_odd_i,
   input  logic                     parity_even_i,
   input  logic                     rx_reset_i,
   input  logic                     uart_rx_i,
   output logic [DATA_WIDTH-1:0]    m_axis_tdata,
   output logic                     m_axis_tuser,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     frame_err_o,
   output logic                     overrun_o
);

   localparam int BIT_W = $clog2(DATA_WIDTH);

`ifdef AXIS_UART_RX_MAJORITY_EN
   localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV = DIVIDER_WIDTH'(4);
   localparam logic [DIVIDER_WIDTH-1:0] LAT     = DIVIDER_WIDTH'(1);
`else
   localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV = DIVIDER_WIDTH'(2);
   localparam logic [DIVIDER_WIDTH-1:0] LAT     = DIVIDER_WIDTH'(0);
`endif

   logic rxs;
   logic rxs_d1_q;
   logic sample_val;

   uart_state_e             state_q,   state_d;
   logic [DIVIDER_WIDTH-1:0] count_q,  count_d;
   logic [DIVIDER_WIDTH-1:0] div_q,    div_d;
   logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]   shift_q,   shift_d;
   logic                    par_en_q,  par_en_d;
   logic                    par_odd_q, par_odd_d;
   uart_rx_status_t         status_q,  status_d;
   logic [DATA_WIDTH-1:0]   tdata_q,   tdata_d;
   logic                    tuser_q,   tuser_d;
   logic                    tvalid_q,  tvalid_d;

   logic [DIVIDER_WIDTH-1:0] half;
   logic [DIVIDER_WIDTH-1:0] target;
   logic                     strobe;
   logic                     deliver;

   axis_uart_rx_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (rx_reset_i),
      .d_i   (uart_rx_i),
      .q_o   (rxs)
   );

`ifdef AXIS_UART_RX_MAJORITY_EN
   logic rxs_d2_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rxs_d1_q <= 1'b1;
         rxs_d2_q <= 1'b1;
      end else if (rx_reset_i) begin
         rxs_d1_q <= 1'b1;
         rxs_d2_q <= 1'b1;
      end else begin
         rxs_d1_q <= rxs;
         rxs_d2_q <= rxs_d1_q;
      end
   end

   // Evaluated one cycle after the nominal point: rxs is count+1, d1 is count, d2 is count-1.
   assign sample_val = (rxs_d2_q & rxs_d1_q) | (rxs_d2_q & rxs) | (rxs_d1_q & rxs);
`else
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rxs_d1_q <= 1'b1;
      end else if (rx_reset_i) begin
         rxs_d1_q <= 1'b1;
      end else begin
         rxs_d1_q <= rxs;
      end
   end

   assign sample_val = rxs;
`endif

   assign half   = div_q >> 1;
   assign target = (state_q == UART_START) ? half - 1'b1 : div_q - 1'b1;
   // Reloading the counter with LAT keeps the bit grid fixed when the vote adds a cycle.
   assign strobe = (count_q == target + LAT);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q + 1'b1;
      div_d      = div_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      status_d   = status_q;
      status_d.overrun   = 1'b0;
      status_d.frame_err = 1'b0;
      tdata_d    = tdata_q;
      tuser_d    = tuser_q;
      tvalid_d   = tvalid_q;
      deliver    = 1'b0;

      case (state_q)
         UART_IDLE: begin
            count_d = '0;
            if (rxs_d1_q && !rxs) begin
               state_d   = UART_START;
               div_d     = (clk_divider_i < MIN_DIV) ? MIN_DIV : clk_divider_i;
               par_en_d  = parity_odd_i | parity_even_i;
               par_odd_d = parity_odd_i;
               status_d.parity_err = 1'b0;
            end
         end
         UART_START: begin
            if (strobe) begin
               count_d = LAT;
               if (sample_val) begin
                  state_d = UART_IDLE;
               end else begin
                  state_d   = UART_DATA;
                  bit_cnt_d = '0;
               end
            end
         end
         UART_DATA: begin
            if (strobe) begin
               count_d   = LAT;
               shift_d   = {sample_val, shift_q[DATA_WIDTH-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? UART_PARITY : UART_STOP;
               end
            end
         end
         UART_PARITY: begin
            if (strobe) begin
               count_d = LAT;
               status_d.parity_err = (sample_val != parity_bit(shift_q, par_odd_q));
               state_d = UART_STOP;
            end
         end
         UART_STOP: begin
            if (strobe) begin
               count_d = '0;
               if (sample_val) begin
                  deliver = 1'b1;
                  state_d = UART_IDLE;
               end else begin
                  status_d.frame_err = 1'b1;
                  state_d = UART_WAIT;
               end
            end
         end
         UART_WAIT: begin
            count_d = '0;
            if (rxs) begin
               state_d = UART_IDLE;
            end
         end
         default: begin
            state_d = UART_IDLE;
            count_d = '0;
         end
      endcase

      if (tvalid_q && m_axis_tready) begin
         tvalid_d = 1'b0;
      end
      // A full register with no handshake this cycle keeps the old byte.
      if (deliver) begin
         if (tvalid_q && !m_axis_tready) begin
            status_d.overrun = 1'b1;
         end else begin
            tvalid_d = 1'b1;
            tdata_d  = shift_q;
            tuser_d  = status_q.parity_err;
         end
      end

      if (rx_reset_i) begin
         state_d   = UART_IDLE;
         count_d   = '0;
         div_d     = '0;
         bit_cnt_d = '0;
         shift_d   = '0;
         par_en_d  = 1'b0;
         par_odd_d = 1'b0;
         status_d  = '0;
         tdata_d   = '0;
         tuser_d   = 1'b0;
         tvalid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= UART_IDLE;
         count_q   <= '0;
         div_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         status_q  <= '0;
         tdata_q   <= '0;
         tuser_q   <= 1'b0;
         tvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         div_q     <= div_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         status_q  <= status_d;
         tdata_q   <= tdata_d;
         tuser_q   <= tuser_d;
         tvalid_q  <= tvalid_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tvalid = tvalid_q;
   assign frame_err_o   = status_q.frame_err;
   assign overrun_o     = status_q.overrun;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed testbench for axis_uart_rx: frames are bit-banged at 16 clocks per bit
// and a negedge monitor logs handshakes and error pulses.
module tb_axis_uart_rx;
   import axis_uart_pkg::*;

   localparam int DIV = 16;

   logic                     clk_i = 1'b0;
   logic                     rst_i = 1'b1;
   logic [DIVIDER_WIDTH-1:0] clk_divider_i = DIVIDER_WIDTH'(DIV);
   logic                     parity_odd_i = 1'b0;
   logic                     parity_even_i = 1'b0;
   logic                     rx_reset_i = 1'b0;
   logic                     uart_rx_i = 1'b1;
   logic [DATA_WIDTH-1:0]    m_axis_tdata;
   logic                     m_axis_tuser;
   logic                     m_axis_tvalid;
   logic                     m_axis_tready = 1'b1;
   logic                     frame_err_o;
   logic                     overrun_o;

   int checks = 0;
   int failures = 0;

   logic [8:0] rx_log [0:63];
   int rx_cnt = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int valid_cycles = 0;

   axis_uart_rx #(.SYNC_STAGES(2)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clk_divider_i (clk_divider_i),
      .parity_odd_i  (parity_odd_i),
      .parity_even_i (parity_even_i),
      .rx_reset_i    (rx_reset_i),
      .uart_rx_i     (uart_rx_i),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .frame_err_o   (frame_err_o),
      .overrun_o     (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (m_axis_tvalid) valid_cycles++;
         if (m_axis_tvalid && m_axis_tready && rx_cnt < 64) begin
            rx_log[rx_cnt] = {m_axis_tuser, m_axis_tdata};
            rx_cnt++;
         end
         if (frame_err_o) fe_cnt++;
         if (overrun_o) ov_cnt++;
      end
   end

   task automatic idle(input int n);
      uart_rx_i = 1'b1;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      uart_rx_i = b;
      repeat (DIV) @(posedge clk_i);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic par_en,
                             input logic par_val, input logic stop_val);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(data[i]);
      if (par_en) drive_bit(par_val);
      drive_bit(stop_val);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata, frame_err_o, overrun_o} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b u=%b d=%h fe=%b ov=%b required all 0",
                  m_axis_tvalid, m_axis_tuser, m_axis_tdata, frame_err_o, overrun_o);
      end
      rst_i = 1'b0;
      idle(40);
   endtask

   task automatic test_basic();
      int base = rx_cnt;
      int vbase = valid_cycles;
      int fbase = fe_cnt;
      int obase = ov_cnt;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (rx_cnt - base !== 1) begin
         failures++;
         $display("FAIL basic_count: got %0d bytes required 1", rx_cnt - base);
      end
      checks++;
      if (rx_log[base] !== 9'h0A5) begin
         failures++;
         $display("FAIL basic_data: got %h required 0a5", rx_log[base]);
      end
      checks++;
      if (valid_cycles - vbase !== 1) begin
         failures++;
         $display("FAIL basic_valid_len: got %0d cycles required 1", valid_cycles - vbase);
      end
      checks++;
      if ((fe_cnt - fbase) + (ov_cnt - obase) !== 0) begin
         failures++;
         $display("FAIL basic_err_pulses: got fe=%0d ov=%0d required 0", fe_cnt - fbase, ov_cnt - obase);
      end
   endtask

   task automatic test_parity();
      int base = rx_cnt;
      parity_even_i = 1'b1;
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      idle(20);
      parity_even_i = 1'b0;
      parity_odd_i  = 1'b1;
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      idle(20);
      parity_odd_i = 1'b0;
      checks++;
      if (rx_cnt - base !== 2) begin
         failures++;
         $display("FAIL parity_count: got %0d bytes required 2", rx_cnt - base);
      end
      checks++;
      if (rx_log[base] !== 9'h103) begin
         failures++;
         $display("FAIL parity_even_bad: got %h required 103", rx_log[base]);
      end
      checks++;
      if (rx_log[base+1] !== 9'h003) begin
         failures++;
         $display("FAIL parity_odd_good: got %h required 003", rx_log[base+1]);
      end
   endtask

   task automatic test_frame_error();
      int base = rx_cnt;
      int fbase = fe_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
      uart_rx_i = 1'b0;
      repeat (40) @(posedge clk_i);
      #1;
      checks++;
      if (fe_cnt - fbase !== 1) begin
         failures++;
         $display("FAIL frame_err_pulse: got %0d pulses required 1", fe_cnt - fbase);
      end
      checks++;
      if (rx_cnt - base !== 0 || m_axis_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL frame_err_no_data: got %0d bytes valid=%b required 0 and 0",
                  rx_cnt - base, m_axis_tvalid);
      end
      idle(32);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (rx_cnt - base !== 1 || rx_log[base] !== 9'h03C || fe_cnt - fbase !== 1) begin
         failures++;
         $display("FAIL frame_err_recover: got n=%0d d=%h fe=%0d required n=1 d=03c fe=1",
                  rx_cnt - base, rx_log[base], fe_cnt - fbase);
      end
   endtask

   task automatic test_overrun();
      int base = rx_cnt;
      int obase = ov_cnt;
      m_axis_tready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      idle(16);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h11) begin
         failures++;
         $display("FAIL overrun_hold: got valid=%b data=%h required 1 11", m_axis_tvalid, m_axis_tdata);
      end
      checks++;
      if (ov_cnt - obase !== 1) begin
         failures++;
         $display("FAIL overrun_pulse: got %0d pulses required 1", ov_cnt - obase);
      end
      m_axis_tready = 1'b1;
      idle(5);
      checks++;
      if (rx_cnt - base !== 1 || rx_log[base] !== 9'h011 || m_axis_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL overrun_drain: got n=%0d d=%h valid=%b required n=1 d=011 valid=0",
                  rx_cnt - base, rx_log[base], m_axis_tvalid);
      end
   endtask

   task automatic test_glitch();
      int base = rx_cnt;
      int fbase = fe_cnt;
      int obase = ov_cnt;
      uart_rx_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      idle(200);
      checks++;
      if (rx_cnt - base !== 0 || m_axis_tvalid !== 1'b0 || fe_cnt - fbase !== 0 || ov_cnt - obase !== 0) begin
         failures++;
         $display("FAIL glitch_ignored: got n=%0d valid=%b fe=%0d ov=%0d required all 0",
                  rx_cnt - base, m_axis_tvalid, fe_cnt - fbase, ov_cnt - obase);
      end
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (rx_cnt - base !== 1 || rx_log[base] !== 9'h05A) begin
         failures++;
         $display("FAIL glitch_recover: got n=%0d d=%h required n=1 d=05a", rx_cnt - base, rx_log[base]);
      end
   endtask

   task automatic test_soft_reset();
      int base = rx_cnt;
      int fbase = fe_cnt;
      logic [7:0] data = 8'hF0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(data[i]);
      uart_rx_i = data[4];
      repeat (8) @(posedge clk_i);
      #1;
      rx_reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      rx_reset_i = 1'b0;
      repeat (7) @(posedge clk_i);
      #1;
      for (int i = 5; i < 8; i++) drive_bit(data[i]);
      drive_bit(1'b1);
      idle(40);
      checks++;
      if (rx_cnt - base !== 0 || m_axis_tvalid !== 1'b0 || fe_cnt - fbase !== 0) begin
         failures++;
         $display("FAIL soft_reset_abort: got n=%0d valid=%b fe=%0d required all 0",
                  rx_cnt - base, m_axis_tvalid, fe_cnt - fbase);
      end
   endtask

   task automatic test_divider_change();
      int base = rx_cnt;
      logic [7:0] data = 8'h96;
      drive_bit(1'b0);
      clk_divider_i = DIVIDER_WIDTH'(32);
      for (int i = 0; i < 8; i++) drive_bit(data[i]);
      drive_bit(1'b1);
      idle(20);
      clk_divider_i = DIVIDER_WIDTH'(DIV);
      idle(80);
      checks++;
      if (rx_cnt - base !== 1 || rx_log[base] !== 9'h096) begin
         failures++;
         $display("FAIL divider_latched: got n=%0d d=%h required n=1 d=096", rx_cnt - base, rx_log[base]);
      end
   endtask

   task automatic test_back_to_back();
      int base = rx_cnt;
      send_frame(8'h00, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (rx_cnt - base !== 2 || rx_log[base] !== 9'h000 || rx_log[base+1] !== 9'h0FF) begin
         failures++;
         $display("FAIL back_to_back: got n=%0d d0=%h d1=%h required n=2 000 0ff",
                  rx_cnt - base, rx_log[base], rx_log[base+1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_frame_error();
      test_overrun();
      test_glitch();
      test_soft_reset();
      test_divider_change();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
